// File: rtl/game_pkg.sv
// Shared keycode constants and encoder state type for the button keycode source.
// Build option: KEY_REPEAT_EN enables auto-repeat while a button stays held.
package game_pkg;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } enc_state_t;

    typedef enum logic [2:0] {
        CAND_NONE,
        CAND_UP,
        CAND_DOWN,
        CAND_LEFT,
        CAND_RIGHT
    } cand_t;

    function automatic logic [7:0] cand_code(input cand_t c);
        logic [7:0] code;
        code = KEY_NONE;
        case (c)
            CAND_UP:    code = KEY_W;
            CAND_DOWN:  code = KEY_S;
            CAND_LEFT:  code = KEY_A;
            CAND_RIGHT: code = KEY_D;
            default:    code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for raw asynchronous button inputs.
// Width is a parameter; both stages clear on reset.
module btn_sync #(
    parameter int W = 4
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages to let metastability settle before use.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_keycode_encoder.sv
// Debounces four push buttons and emits one W/A/S/D keycode per press.
// Build option: KEY_REPEAT_EN adds auto-repeat while the same button is held.
module button_keycode_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int CNT_W           = 6,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       key_ready,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic [7:0] key_count
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

    localparam bit CFG_OK =
        (DEBOUNCE_FRAMES >= 1) && (DEBOUNCE_FRAMES <= CNT_MAX) &&
        (REPEAT_DELAY >= 2)    && (REPEAT_DELAY <= CNT_MAX) &&
        (REPEAT_PERIOD >= 2)   && (REPEAT_PERIOD <= CNT_MAX);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("count parameters do not fit CNT_W");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [3:0] btn_raw;
    logic [3:0] btn_s;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    btn_sync #(
        .W(4)
    ) u_sync (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .d        (btn_raw),
        .q        (btn_s)
    );

    cand_t      cand;
    logic       has_cand;
    logic       xfer;

    enc_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    cand_t      latched, latched_nxt;
    logic [7:0] code_nxt;
    logic       valid_nxt;
    logic [7:0] count_nxt;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 2);

    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             rpt_armed, rpt_armed_nxt;
    logic [CNT_W-1:0] rpt_last;

    assign rpt_last = rpt_armed ? RP_LAST : RD_LAST;
`endif

    // Priority encode the synced buttons: up > down > left > right.
    always_comb begin
        cand = CAND_NONE;
        if (btn_s[3])
            cand = CAND_UP;
        else if (btn_s[2])
            cand = CAND_DOWN;
        else if (btn_s[1])
            cand = CAND_LEFT;
        else if (btn_s[0])
            cand = CAND_RIGHT;
    end

    assign has_cand = (cand != CAND_NONE);
    assign xfer     = key_valid && key_ready;

    // Next-state, counters and output register values.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        latched_nxt = latched;
        code_nxt    = keycode;
        valid_nxt   = key_valid;
        count_nxt   = key_count;
`ifdef KEY_REPEAT_EN
        rpt_cnt_nxt   = rpt_cnt;
        rpt_armed_nxt = rpt_armed;
`endif
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (has_cand) begin
                    state_nxt   = DEBOUNCE;
                    latched_nxt = cand;
                    cnt_nxt     = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!has_cand) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cand != latched) begin
                    latched_nxt = cand;
                    cnt_nxt     = CNT_W'(1);
                end else if (cnt == DB_LAST) begin
                    state_nxt = EMIT;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    code_nxt  = cand_code(latched);
`ifdef KEY_REPEAT_EN
                    rpt_armed_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            EMIT: begin
                if (xfer) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    code_nxt  = KEY_NONE;
                    count_nxt = key_count + 8'd1;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_nxt = '0;
`endif
                end
            end
            WAIT_RELEASE: begin
                if (has_cand) begin
                    cnt_nxt = '0;
`ifdef KEY_REPEAT_EN
                    if (cand == latched) begin
                        if (rpt_cnt == rpt_last) begin
                            state_nxt     = EMIT;
                            valid_nxt     = 1'b1;
                            code_nxt      = cand_code(latched);
                            rpt_armed_nxt = 1'b1;
                            rpt_cnt_nxt   = '0;
                        end else begin
                            rpt_cnt_nxt = sat_inc(rpt_cnt);
                        end
                    end else begin
                        rpt_cnt_nxt   = '0;
                        rpt_armed_nxt = 1'b0;
                    end
`endif
                end else begin
`ifdef KEY_REPEAT_EN
                    rpt_cnt_nxt   = '0;
                    rpt_armed_nxt = 1'b0;
`endif
                    if (cnt == REL_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                valid_nxt = 1'b0;
                code_nxt  = KEY_NONE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            latched   <= CAND_NONE;
            keycode   <= KEY_NONE;
            key_valid <= 1'b0;
            key_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            latched   <= latched_nxt;
            keycode   <= code_nxt;
            key_valid <= valid_nxt;
            key_count <= count_nxt;
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat frame counter and first/subsequent repeat flag.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_armed <= rpt_armed_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_button_keycode_encoder.sv
// Bench for button_keycode_encoder: press table, debounce corners, reset.
// Expected keycodes go to a queue and are popped on each transfer.
module tb_button_keycode_encoder;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       key_ready;
    logic [7:0] keycode;
    logic       key_valid;
    logic [7:0] key_count;

    button_keycode_encoder dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .key_ready(key_ready),
        .keycode  (keycode),
        .key_valid(key_valid),
        .key_count(key_count)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [3:0] btns;
        logic [7:0] code;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         exp_count = 0;
    int         xfers = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: idle code is zero, every transfer matches the scoreboard.
    always @(negedge frame_clk) begin
        if (!Reset) begin
            if (!key_valid)
                check("idle_code", {24'd0, keycode}, 32'h0);
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer actual=%0h required=none",
                             keycode);
                end else begin
                    check("xfer_code", {24'd0, keycode},
                          {24'd0, exp_q.pop_front()});
                end
                check("xfer_count", {24'd0, key_count},
                      exp_count & 32'hFF);
                exp_count++;
                xfers++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge frame_clk);
            #1;
            if (key_valid && lat < 0)
                lat = i;
            if (lat >= 0)
                break;
        end
    endtask

    vec_t vecs[8];
    int   lat;
    int   x0;
    int   n_rep;

    initial begin
        vecs[0] = '{4'b0010, 8'h04};
        vecs[1] = '{4'b1000, 8'h1A};
        vecs[2] = '{4'b0100, 8'h16};
        vecs[3] = '{4'b0001, 8'h07};
        vecs[4] = '{4'b1100, 8'h1A};
        vecs[5] = '{4'b0111, 8'h16};
        vecs[6] = '{4'b0011, 8'h04};
        vecs[7] = '{4'b1111, 8'h1A};

        Reset     = 1'b1;
        key_ready = 1'b1;
        set_btn(4'b0000);
        tick(3);
        check("rst_code", {24'd0, keycode}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'h0);
        check("rst_count", {24'd0, key_count}, 32'h0);
        Reset = 1'b0;
        tick(2);

        // Table: one press per vector, latency 6 edges after drive.
        for (int v = 0; v < 8; v++) begin
            x0 = xfers;
            exp_q.push_back(vecs[v].code);
            set_btn(vecs[v].btns);
            wait_valid(lat);
            check("latency", lat, 6);
            check("vec_code", {24'd0, keycode}, {24'd0, vecs[v].code});
            tick(1);
            check("one_frame", {31'd0, key_valid}, 32'h0);
            tick(8);
            check("single_key", xfers - x0, 1);
            set_btn(4'b0000);
            tick(8);
        end

        // Release for exactly 3 frames is enough to re-arm.
        x0 = xfers;
        exp_q.push_back(8'h04);
        set_btn(4'b0010);
        wait_valid(lat);
        check("rearm_first", lat, 6);
        tick(4);
        set_btn(4'b0000);
        tick(3);
        exp_q.push_back(8'h04);
        set_btn(4'b0010);
        wait_valid(lat);
        check("rearm_lat", lat, 6);
        tick(4);
        check("rearm_keys", xfers - x0, 2);
        set_btn(4'b0000);

        // Release for only 2 frames does not re-arm.
        tick(2);
        set_btn(4'b0010);
        tick(15);
        check("short_release", xfers - x0, 2);
        set_btn(4'b0000);
        tick(8);

        // Short pulse of up: no key, then IDLE again.
        x0 = xfers;
        set_btn(4'b1000);
        tick(2);
        set_btn(4'b0000);
        tick(12);
        check("pulse_nokey", xfers - x0, 0);
        exp_q.push_back(8'h04);
        set_btn(4'b0010);
        wait_valid(lat);
        check("pulse_idle", lat, 6);
        set_btn(4'b0000);
        tick(8);

        // Down held with ready low, release while pending.
        key_ready = 1'b0;
        x0 = xfers;
        exp_q.push_back(8'h16);
        set_btn(4'b0100);
        wait_valid(lat);
        check("hold_lat", lat, 6);
        tick(10);
        set_btn(4'b0000);
        tick(5);
        check("hold_valid", {31'd0, key_valid}, 32'h1);
        check("hold_code", {24'd0, keycode}, 32'h16);
        check("hold_noxfer", xfers - x0, 0);
        key_ready = 1'b1;
        tick(1);
        check("hold_xfer", xfers - x0, 1);
        check("hold_drop", {31'd0, key_valid}, 32'h0);
        check("hold_count", {24'd0, key_count}, exp_count & 32'hFF);
        tick(8);

        // Right and up together: up wins, no key on partial release.
        x0 = xfers;
        exp_q.push_back(8'h1A);
        set_btn(4'b1001);
        wait_valid(lat);
        check("combo_lat", lat, 6);
        check("combo_code", {24'd0, keycode}, 32'h1A);
        tick(3);
        set_btn(4'b0001);
        tick(12);
        check("combo_keys", xfers - x0, 1);
        set_btn(4'b0000);
        tick(8);
        exp_q.push_back(8'h04);
        set_btn(4'b0010);
        wait_valid(lat);
        check("combo_idle", lat, 6);
        set_btn(4'b0000);
        tick(8);

        // Long hold of right: repeat only when enabled.
        x0 = xfers;
`ifdef KEY_REPEAT_EN
        n_rep = 5;
`else
        n_rep = 1;
`endif
        for (int i = 0; i < n_rep; i++)
            exp_q.push_back(8'h07);
        set_btn(4'b0001);
        tick(70);
        set_btn(4'b0000);
        tick(8);
        check("repeat_keys", xfers - x0, n_rep);
        check("repeat_drain", exp_q.size(), 0);

        // Asynchronous reset while a key is pending.
        key_ready = 1'b0;
        set_btn(4'b0100);
        wait_valid(lat);
        check("rst_pend_lat", lat, 6);
        x0 = xfers;
        #2;
        Reset = 1'b1;
        exp_q.delete();
        exp_count = 0;
        #1;
        check("arst_code", {24'd0, keycode}, 32'h0);
        check("arst_valid", {31'd0, key_valid}, 32'h0);
        check("arst_count", {24'd0, key_count}, 32'h0);
        set_btn(4'b0000);
        tick(2);
        Reset = 1'b0;
        key_ready = 1'b1;
        tick(10);
        check("arst_discard", xfers - x0, 0);
        exp_q.push_back(8'h1A);
        set_btn(4'b1000);
        wait_valid(lat);
        check("arst_lat", lat, 6);
        set_btn(4'b0000);
        tick(8);
        check("final_count", {24'd0, key_count}, 32'h1);
        check("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
